// File: rtl/evo_xb_info_pkg.sv
// Shared definitions for the XB info-table scanner: bus width defaults,
// scanner state encoding and the well-known info table indices.
package evo_xb_info_pkg;

   localparam int CSR_AWIDTH_DEF = 8;
   localparam int CSR_DWIDTH_DEF = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_IDX  = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      EMIT    = 3'd4,
      FINISH  = 3'd5
   } scan_state_e;

   // Index 0 holds the count of entries that follow it.
   localparam logic [7:0] INFO_IDX_NUM    = 8'd0;
   localparam logic [7:0] INFO_IDX_VENDOR = 8'd1;
   localparam logic [7:0] INFO_IDX_MODEL  = 8'd2;
   localparam logic [7:0] INFO_IDX_TYPE   = 8'd3;

endpackage

// File: rtl/evo_bus_timeout.sv
// Bus wait watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the wait has lasted CYCLES cycles.
module evo_bus_timeout #(
   parameter int CYCLES = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign expired = enable && (count_q == CW'(CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/evo_xb_info_scan.sv
// Walks the XB info table through an indirect CSR (write index, read value)
// and streams every entry out; entry 0 gives how many entries follow.
module evo_xb_info_scan
   import evo_xb_info_pkg::*;
#(
   parameter int                    CSR_AWIDTH     = CSR_AWIDTH_DEF,
   parameter int                    CSR_DWIDTH     = CSR_DWIDTH_DEF,
   parameter logic [CSR_AWIDTH-1:0] INFO_CSR_ADDR  = '0,
   parameter int                    MAX_ENTRIES    = 16,
   parameter int                    TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  truncated,
   output logic [CSR_AWIDTH-1:0] avm_csr_address,
   output logic                  avm_csr_read,
   output logic                  avm_csr_write,
   output logic [CSR_DWIDTH-1:0] avm_csr_writedata,
   input  logic [CSR_DWIDTH-1:0] avm_csr_readdata,
   input  logic                  avm_csr_readdatavalid,
   input  logic                  avm_csr_waitrequest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_index,
   output logic [CSR_DWIDTH-1:0] out_data,
   output logic [2:0]            dbg_state
);

   scan_state_e           state_q, state_d;
   logic [7:0]            index_q, index_d;
   logic [7:0]            last_q, last_d;
   logic                  error_q, error_d;
   logic                  trunc_q, trunc_d;
   logic [7:0]            out_index_q, out_index_d;
   logic [CSR_DWIDTH-1:0] out_data_q, out_data_d;
   logic                  capture;
   logic                  tmo_enable;
   logic                  tmo_clear;
   logic                  tmo_expired;

   assign tmo_enable = (state_q == WR_IDX) || (state_q == RD_REQ) || (state_q == RD_WAIT);
   assign tmo_clear  = (state_d != state_q);

   evo_bus_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      last_d      = last_q;
      error_d     = error_q;
      trunc_d     = trunc_q;
      out_index_d = out_index_q;
      out_data_d  = out_data_q;
      capture     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               index_d = '0;
               last_d  = '0;
               error_d = 1'b0;
               trunc_d = 1'b0;
               state_d = WR_IDX;
            end
         end
         WR_IDX: begin
            if (!avm_csr_waitrequest) begin
               state_d = RD_REQ;
            end else if (tmo_expired) begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            // A zero-latency slave may return data in the accept cycle.
            if (!avm_csr_waitrequest) begin
               if (avm_csr_readdatavalid) begin
                  capture = 1'b1;
               end else begin
                  state_d = RD_WAIT;
               end
            end else if (tmo_expired) begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (avm_csr_readdatavalid) begin
               capture = 1'b1;
            end else if (tmo_expired) begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         // Entry stream: an entry transfers in a cycle with out_valid and
         // out_ready both high; out_index/out_data hold steady until then.
         EMIT: begin
            if (out_ready) begin
               if (index_q == last_q) begin
                  state_d = FINISH;
               end else begin
                  index_d = index_q + 8'd1;
                  state_d = WR_IDX;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (capture) begin
         out_data_d  = avm_csr_readdata;
         out_index_d = index_q;
         state_d     = EMIT;
         if (index_q == INFO_IDX_NUM) begin
            if (avm_csr_readdata > CSR_DWIDTH'(MAX_ENTRIES)) begin
               last_d  = 8'(MAX_ENTRIES);
               trunc_d = 1'b1;
            end else begin
               last_d = 8'(avm_csr_readdata);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         index_q     <= '0;
         last_q      <= '0;
         error_q     <= 1'b0;
         trunc_q     <= 1'b0;
         out_index_q <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         last_q      <= last_d;
         error_q     <= error_d;
         trunc_q     <= trunc_d;
         out_index_q <= out_index_d;
         out_data_q  <= out_data_d;
      end
   end

   always_comb begin
      avm_csr_write     = (state_q == WR_IDX);
      avm_csr_read      = (state_q == RD_REQ);
      avm_csr_address   = '0;
      avm_csr_writedata = '0;
      if ((state_q == WR_IDX) || (state_q == RD_REQ)) begin
         avm_csr_address = INFO_CSR_ADDR;
      end
      if (state_q == WR_IDX) begin
         avm_csr_writedata = CSR_DWIDTH'(index_q);
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign error     = error_q;
   assign truncated = trunc_q;
   assign out_valid = (state_q == EMIT);
   assign out_index = out_index_q;
   assign out_data  = out_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_evo_xb_info_scan.sv
// Bench for evo_xb_info_scan: behavioural info-table slave and stream sink,
// reference entry list built from the table contents, scenario sequence.
module tb_evo_xb_info_scan;
   import evo_xb_info_pkg::*;

   localparam int         MAXE     = 16;
   localparam int         TMO      = 64;
   localparam logic [7:0] CSR_ADDR = 8'h2C;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic        truncated;
   logic [7:0]  avm_csr_address;
   logic        avm_csr_read;
   logic        avm_csr_write;
   logic [31:0] avm_csr_writedata;
   logic [31:0] avm_csr_readdata;
   logic        avm_csr_readdatavalid;
   logic        avm_csr_waitrequest;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_index;
   logic [31:0] out_data;
   logic [2:0]  dbg_state;

   evo_xb_info_scan #(
      .CSR_AWIDTH     (8),
      .CSR_DWIDTH     (32),
      .INFO_CSR_ADDR  (CSR_ADDR),
      .MAX_ENTRIES    (MAXE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .start                 (start),
      .busy                  (busy),
      .done                  (done),
      .error                 (error),
      .truncated             (truncated),
      .avm_csr_address       (avm_csr_address),
      .avm_csr_read          (avm_csr_read),
      .avm_csr_write         (avm_csr_write),
      .avm_csr_writedata     (avm_csr_writedata),
      .avm_csr_readdata      (avm_csr_readdata),
      .avm_csr_readdatavalid (avm_csr_readdatavalid),
      .avm_csr_waitrequest   (avm_csr_waitrequest),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .out_index             (out_index),
      .out_data              (out_data),
      .dbg_state             (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard and counters
   logic [39:0] exp_q[$];
   logic [31:0] info_mem [256];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   int          both_cnt = 0;
   int          proto_err = 0;
   int          addr_err = 0;
   int          hs_cnt = 0;

   // agent configuration and state
   bit          rand_mode = 1'b0;
   int          stuck_idx = -1;
   int          stall_idx = 3;
   int          stall_left = 0;
   bit          stalling = 1'b0;
   logic [7:0]  st_idx;
   logic [31:0] st_data;
   int          pend = 0;
   int          lat;
   logic [31:0] rd_hold;
   logic [7:0]  slave_idx = 8'd0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void load_default();
      for (int i = 0; i < 256; i++) info_mem[i] = $urandom;
      info_mem[INFO_IDX_NUM]    = 32'd6;
      info_mem[INFO_IDX_VENDOR] = 32'h414C4F20;
      info_mem[INFO_IDX_MODEL]  = 32'h45564F20;
      info_mem[INFO_IDX_TYPE]   = 32'h53455256;
      info_mem[4]               = 32'hFFFFFFFF;
      info_mem[5]               = 32'hC0FFEE01;
      info_mem[6]               = 32'h54455354;
   endfunction

   // Reference: entries 0..min(NUM, MAXE) in order; returns expected truncated.
   function automatic bit build_exp(input int max_cnt);
      logic [31:0] num;
      int          last;
      num  = info_mem[0];
      last = (num > 32'(MAXE)) ? MAXE : int'(num);
      exp_q.delete();
      for (int i = 0; i <= last && i < max_cnt; i++) exp_q.push_back({8'(i), info_mem[i]});
      return (num > 32'(MAXE));
   endfunction

   // Info CSR slave and entry sink, evaluated mid-cycle.
   task automatic agent();
      logic [39:0] e;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pend = 0;
            avm_csr_waitrequest = 1'b0;
            avm_csr_readdatavalid = 1'b0;
            out_ready = 1'b0;
            stalling = 1'b0;
         end else begin
            if (avm_csr_read && avm_csr_write) both_cnt++;
            if ((avm_csr_read || avm_csr_write) && avm_csr_address != CSR_ADDR) addr_err++;
            if (done) done_cnt++;
            avm_csr_readdatavalid = 1'b0;
            avm_csr_readdata = $urandom;
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  avm_csr_readdatavalid = 1'b1;
                  avm_csr_readdata = rd_hold;
               end
            end
            if (avm_csr_write && stuck_idx >= 0 && avm_csr_writedata == 32'(stuck_idx))
               avm_csr_waitrequest = 1'b1;
            else if (rand_mode)
               avm_csr_waitrequest = ($urandom_range(0, 3) == 0);
            else
               avm_csr_waitrequest = 1'b0;
            if ((avm_csr_read || avm_csr_write) && !avm_csr_waitrequest) begin
               if (pend > 0) proto_err++;
               if (avm_csr_write) begin
                  slave_idx = avm_csr_writedata[7:0];
               end else begin
                  lat = rand_mode ? int'($urandom_range(0, 2)) : 1;
                  if (lat == 0) begin
                     avm_csr_readdatavalid = 1'b1;
                     avm_csr_readdata = info_mem[slave_idx];
                  end else begin
                     pend = lat;
                     rd_hold = info_mem[slave_idx];
                  end
               end
            end
            if (stall_left > 0 && (stalling || (out_valid && out_index == 8'(stall_idx)))) begin
               if (!stalling) begin
                  stalling = 1'b1;
                  st_idx = out_index;
                  st_data = out_data;
               end else begin
                  chk("stall_valid", out_valid, 1);
                  chk("stall_index", out_index, 8'(stall_idx));
                  chk("stall_data", out_data, st_data);
               end
               chk("stall_bus_idle", {avm_csr_read, avm_csr_write}, 0);
               out_ready = 1'b0;
               stall_left--;
               if (stall_left == 0) stalling = 1'b0;
            end else begin
               out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (out_valid && out_ready) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_entry", {out_index, out_data}, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("entry", {out_index, out_data}, e);
               end
            end
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_truncated"}, truncated, 0);
      chk({tag, "_read"}, avm_csr_read, 0);
      chk({tag, "_write"}, avm_csr_write, 0);
      chk({tag, "_address"}, avm_csr_address, 0);
      chk({tag, "_writedata"}, avm_csr_writedata, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_index"}, out_index, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_state"}, dbg_state, 0);
   endtask

   // Pulses start, waits (bounded) for busy to drop, then checks the outcome.
   task automatic run_scan(input bit exp_trunc, input int exp_done, input bit exp_err,
                           input int exp_cycles, input bit spam);
      int cyc;
      int d0, b0, p0, a0;
      d0 = done_cnt; b0 = both_cnt; p0 = proto_err; a0 = addr_err;
      cyc = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (busy && cyc < 3000) begin
         cyc++;
         start = spam && ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      chk("scan_finished_in_bound", (cyc < 3000), 1);
      if (exp_cycles > 0) chk("scan_cycles", 64'(cyc), 64'(exp_cycles));
      chk("done_pulses", 64'(done_cnt - d0), 64'(exp_done));
      chk("error_flag", error, exp_err);
      chk("truncated_flag", truncated, exp_trunc);
      chk("missing_entries", 64'(exp_q.size()), 0);
      chk("rd_wr_overlap", 64'(both_cnt - b0), 0);
      chk("outstanding", 64'(proto_err - p0), 0);
      chk("bus_address", 64'(addr_err - a0), 0);
      chk("write_after_scan", avm_csr_write, 0);
      chk("read_after_scan", avm_csr_read, 0);
   endtask

   initial begin
      bit          tr;
      int          cyc;
      int          hs0;
      logic [31:0] nums [5];

      rstn = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      avm_csr_waitrequest = 1'b0;
      avm_csr_readdatavalid = 1'b0;
      avm_csr_readdata = '0;
      fork
         agent();
      join_none
      load_default();
      repeat (3) @(negedge clk);
      check_zero("por");
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Reference table, zero-wait slave, 4 cycles per entry plus the done cycle.
      rand_mode = 1'b0;
      tr = build_exp(256);
      run_scan(tr, 1, 0, 4 * exp_q.size() + 1, 0);

      // Sink back-pressure on entry 3 for 5 cycles.
      load_default();
      tr = build_exp(256);
      stall_idx = 3;
      stall_left = 5;
      run_scan(tr, 1, 0, 4 * exp_q.size() + 1 + 5, 0);

      // NUM boundaries, including a value whose low byte alone would fit.
      nums[0] = 32'd0;
      nums[1] = 32'd16;
      nums[2] = 32'd17;
      nums[3] = 32'd40;
      nums[4] = 32'hFFFF_FF05;
      for (int k = 0; k < 5; k++) begin
         load_default();
         info_mem[0] = nums[k];
         tr = build_exp(256);
         run_scan(tr, 1, 0, 4 * exp_q.size() + 1, 0);
      end

      // Random waits, read latency 0..2, random ready, start pulses while busy.
      rand_mode = 1'b1;
      for (int r = 0; r < 5; r++) begin
         load_default();
         info_mem[0] = $urandom_range(0, 20);
         tr = build_exp(256);
         run_scan(tr, 1, 0, 0, 1);
      end
      rand_mode = 1'b0;

      // Write of index 2 never accepted: entries 0 and 1, then a 64-cycle timeout.
      load_default();
      tr = build_exp(2);
      stuck_idx = 2;
      run_scan(1'b0, 0, 1, 8 + TMO, 0);
      stuck_idx = -1;

      // A fresh scan clears the error.
      tr = build_exp(256);
      run_scan(tr, 1, 0, 4 * exp_q.size() + 1, 0);

      // Reset while waiting for read data, then a clean scan after release.
      load_default();
      tr = build_exp(256);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hs0 = hs_cnt;
      cyc = 0;
      while (!((hs_cnt - hs0) >= 2 && dbg_state == RD_WAIT) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_rd_wait", (cyc < 500), 1);
      rstn = 1'b0;
      #1;
      check_zero("mid_reset");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk("no_restart_busy", busy, 0);
      chk("no_restart_write", avm_csr_write, 0);
      tr = build_exp(256);
      run_scan(tr, 1, 0, 4 * exp_q.size() + 1, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/evo_xb_info_scan.md
EVO_XB_INFO_SCAN -- requirements
Module: evo_xb_info_scan

Interface
REQ-001 SHALL have parameter CSR_AWIDTH, default 8, CSR address width.
REQ-002 SHALL have parameter CSR_DWIDTH, default 32, CSR data width.
REQ-003 SHALL have parameter INFO_CSR_ADDR, default 8'h0, bus address of the XB info indirect CSR.
REQ-004 SHALL have parameter MAX_ENTRIES, default 16, maximum additional entries fetched; range 1..255.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for waitrequest or readdatavalid.
REQ-006 SHALL have port clk, input, 1 bit, clock, rising edge.
REQ-007 SHALL have port rstn, input, 1 bit, reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1 bit, single-cycle scan request.
REQ-009 SHALL have port busy, output, 1 bit, scan in progress.
REQ-010 SHALL have port done, output, 1 bit, one-cycle pulse on successful scan completion.
REQ-011 SHALL have port error, output, 1 bit, sticky bus-timeout flag, cleared by start.
REQ-012 SHALL have port truncated, output, 1 bit, sticky flag set when NUM exceeds MAX_ENTRIES, cleared by start.
REQ-013 SHALL have ports avm_csr_address (out, CSR_AWIDTH), avm_csr_read (out, 1), avm_csr_write (out, 1), avm_csr_writedata (out, CSR_DWIDTH), avm_csr_readdata (in, CSR_DWIDTH), avm_csr_readdatavalid (in, 1) and avm_csr_waitrequest (in, 1), forming the Avalon-MM master to the info CSR.
REQ-014 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_index (out, 8) and out_data (out, CSR_DWIDTH), forming the entry stream.

Function
REQ-015 SHALL implement states IDLE, WR_IDX, RD_REQ, RD_WAIT, EMIT, FINISH.
REQ-016 IDLE: on start, SHALL set index to 0 and last to 0, clear error and truncated, and go to WR_IDX; busy SHALL be 1 in every state except IDLE.
REQ-017 WR_IDX: SHALL drive write=1, address=INFO_CSR_ADDR and writedata=zero-extended index, held stable while waitrequest=1; on waitrequest=0 SHALL go to RD_REQ.
REQ-018 RD_REQ: SHALL drive read=1 and address=INFO_CSR_ADDR, held while waitrequest=1; on waitrequest=0 SHALL go to RD_WAIT.
REQ-019 RD_WAIT: on readdatavalid=1 SHALL capture readdata into out_data, set out_index=index and go to EMIT; if readdatavalid arrives in the same cycle as the read is accepted, it SHALL be captured in that cycle.
REQ-020 At index 0, the captured value SHALL set last=min(value, MAX_ENTRIES); truncated SHALL be set if value>MAX_ENTRIES, with the comparison done at full CSR_DWIDTH.
REQ-021 EMIT: SHALL assert out_valid with out_index and out_data stable until out_ready=1; on handshake, if index==last SHALL go to FINISH, else SHALL increment index and go to WR_IDX.
REQ-022 FINISH: SHALL pulse done for one cycle and go to IDLE.
REQ-023 A timeout counter SHALL reset on each state entry and count cycles in WR_IDX, RD_REQ and RD_WAIT; on reaching TIMEOUT_CYCLES it SHALL drop read/write, set error, skip done and go to IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 At most one write or read SHALL be outstanding; read and write SHALL never both be asserted.
REQ-026 Scan latency with zero-wait slave, 1-cycle readdatavalid and out_ready=1 SHALL be 4 cycles per entry.
REQ-027 NUM=0 SHALL emit only entry 0, followed by done.

Reset
REQ-028 On rstn=0 all outputs SHALL go to 0 (busy, done, error, truncated, read, write, address, writedata, out_valid, out_index, out_data), the state SHALL go to IDLE, and the counters SHALL go to 0.
REQ-029 Reset mid-scan SHALL abort immediately; the next scan SHALL require a new start.

Structure
REQ-030 Package evo_xb_info_pkg SHALL hold CSR_AWIDTH/CSR_DWIDTH defaults, the state enum and the info index constants (NUM=0, VENDOR=1, MODEL=2, TYPE=3).
REQ-031 The timeout counter SHALL be sub-module evo_bus_timeout (inputs clear and enable; output expired).

Verification
REQ-032 Connect to info slave with NUM=6, VENDOR="ALO ", MODEL="EVO ", TYPE="SERV"; pulse start -> 7 entries, indices 0..6, data 6, 0x414C4F20, 0x45564F20, 0x53455256, 0xFFFFFFFF, 0xC0FFEE01, 0x54455354; one done pulse.
REQ-033 Slave NUM=40, MAX_ENTRIES=16 -> entries 0..16 emitted, truncated=1, done=1.
REQ-034 out_ready low for 5 cycles at entry 3 -> out_valid held with index 3 stable; no bus activity; scan resumes correctly.
REQ-035 waitrequest stuck at 1 on the write of index 2 -> after 64 cycles error=1, busy=0, no done, write=0.
REQ-036 Assert rstn low while in RD_WAIT -> all outputs 0 and state IDLE; start after release -> full 7-entry scan.
REQ-037 Pulse start while busy -> ignored; entry count unchanged.
